// File: rtl/opcode_sequencer.sv
// Program-store sequencer that issues registered opcode/execute pairs to the core array.
// HALT, SETLOOP and LOOP are consumed here and are never broadcast to the cores.
module opcode_sequencer #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_WIDTH = $clog2(PROG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [15:0]           prog_wdata,
  input  logic                  start,
  input  logic                  stall,
  output logic [15:0]           opcode,
  output logic                  execute,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] pc
);

  localparam logic [15:0]           HALT_WORD = 16'hC010;
  localparam logic [ADDR_WIDTH-1:0] LAST_PC   = ADDR_WIDTH'(PROG_DEPTH - 1);

  localparam logic [3:0] OP_HALT    = 4'h1;
  localparam logic [3:0] OP_SETLOOP = 4'h2;
  localparam logic [3:0] OP_LOOP    = 4'h3;

  // S_END is the implicit HALT that follows an instruction at the last address.
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_END
  } state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   pc_n;
  logic [4:0]              loop_cnt, loop_cnt_n;
  logic [15:0]             opcode_n;
  logic                    execute_n, busy_n, done_n;
  logic [15:0]             mem [PROG_DEPTH];
  logic [15:0]             instr;
  logic                    is_seq;
  logic [ADDR_WIDTH-1:0]   target;
  logic                    do_adv, do_halt;

  assign instr  = mem[pc];
  assign is_seq = (instr[15:14] == 2'b11) && !instr[8];
  assign target = instr[9 +: ADDR_WIDTH];

  // NOTE: the store has to come out of reset full of HALT, so the array sits
  // on the async reset like any other register instead of being left undefined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROG_DEPTH; i++) mem[i] <= HALT_WORD;
    end else if (prog_we && state == S_IDLE) begin
      mem[prog_addr] <= prog_wdata;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves one unassigned and infers a latch.
    state_n    = state;
    pc_n       = pc;
    loop_cnt_n = loop_cnt;
    opcode_n   = opcode;
    execute_n  = 1'b0;
    busy_n     = busy;
    done_n     = 1'b0;
    do_adv     = 1'b0;
    do_halt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = '0;
          busy_n  = 1'b1;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (is_seq && instr[7:4] == OP_HALT) begin
            do_halt = 1'b1;
          end else if (is_seq && instr[7:4] == OP_SETLOOP) begin
            loop_cnt_n = instr[13:9];
            do_adv     = 1'b1;
          end else if (is_seq && instr[7:4] == OP_LOOP) begin
            if (loop_cnt != '0) begin
              loop_cnt_n = loop_cnt - 5'd1;
              pc_n       = target;
            end else begin
              do_adv = 1'b1;
            end
          end else begin
            opcode_n  = instr;
            execute_n = 1'b1;
            do_adv    = 1'b1;
          end
        end
      end
      S_END: begin
        if (!stall) do_halt = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase

    // Stepping past the last address parks in S_END rather than wrapping to 0.
    if (do_adv) begin
      if (pc == LAST_PC) state_n = S_END;
      else               pc_n    = pc + 1'b1;
    end

    if (do_halt) begin
      state_n = S_IDLE;
      pc_n    = '0;
      busy_n  = 1'b0;
      done_n  = 1'b1;
    end
  end

  // NOTE: registered state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      pc       <= '0;
      loop_cnt <= '0;
      opcode   <= '0;
      execute  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      loop_cnt <= loop_cnt_n;
      opcode   <= opcode_n;
      execute  <= execute_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

endmodule

// File: tb/tb_opcode_sequencer.sv
// Directed bench for opcode_sequencer: halt-only run, straight-line issue, looping,
// stall, full store with write lockout, and reset in the middle of a run.
module tb_opcode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic        start;
  logic        stall;
  logic [15:0] opcode;
  logic        execute;
  logic        busy;
  logic        done;
  logic [4:0]  pc;

  int n_cmp = 0;
  int n_bad = 0;

  opcode_sequencer #(.PROG_DEPTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .start      (start),
    .stall      (stall),
    .opcode     (opcode),
    .execute    (execute),
    .busy       (busy),
    .done       (done),
    .pc         (pc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] a, input logic [15:0] d);
    prog_we    = 1'b1;
    prog_addr  = a;
    prog_wdata = d;
    step();
    prog_we    = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    logic [7:0]  pat;
    int          cnt;
    int          done_cyc;
    logic [4:0]  done_pc;

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    start = 1'b0; stall = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();

    // Reset state.
    check("rst_opcode", opcode, 16'h0);
    check("rst_exec",   execute, 1'b0);
    check("rst_busy",   busy, 1'b0);
    check("rst_done",   done, 1'b0);
    check("rst_pc",     pc, 5'd0);

    // Store is all HALT: run ends at once.
    pulse_start();
    check("halt_busy1", busy, 1'b1);
    check("halt_exec1", execute, 1'b0);
    check("halt_done1", done, 1'b0);
    step();
    check("halt_done2", done, 1'b1);
    check("halt_busy2", busy, 1'b0);
    check("halt_exec2", execute, 1'b0);
    step();
    check("halt_done3", done, 1'b0);

    // Straight-line program.
    write(5'd0, 16'h0105);
    write(5'd1, 16'h4208);
    write(5'd2, 16'hC010);
    pulse_start();
    check("lin_exec0", execute, 1'b0);
    step();
    check("lin_exec1", execute, 1'b1);
    check("lin_op1",   opcode, 16'h0105);
    step();
    check("lin_exec2", execute, 1'b1);
    check("lin_op2",   opcode, 16'h4208);
    step();
    check("lin_done",  done, 1'b1);
    check("lin_exec3", execute, 1'b0);
    step();

    // SETLOOP 2 / body / LOOP->1 / HALT: body three times with bubbles.
    write(5'd0, 16'hC420);
    write(5'd1, 16'h8000);
    write(5'd2, 16'hC230);
    write(5'd3, 16'hC010);
    pulse_start();
    pat = '0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      pat = {pat[6:0], execute};
      if (execute && opcode == 16'h8000) cnt++;
    end
    check("loop_pattern", pat, 8'b0101_0100);
    check("loop_count",   cnt, 3);
    check("loop_done",    done, 1'b1);
    step();

    // Stall for 4 cycles after the second issue.
    write(5'd0, 16'h0011);
    write(5'd1, 16'h0022);
    write(5'd2, 16'h0033);
    write(5'd3, 16'h0044);
    write(5'd4, 16'h0055);
    write(5'd5, 16'hC010);
    pulse_start();
    step();
    check("stl_op1", opcode, 16'h0011);
    step();
    check("stl_op2", opcode, 16'h0022);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("stl_exec_%0d", i), execute, 1'b0);
      check($sformatf("stl_pc_%0d", i),   pc, 5'd2);
      check($sformatf("stl_hold_%0d", i), opcode, 16'h0022);
    end
    stall = 1'b0;
    step();
    check("stl_op3", {execute, opcode}, {1'b1, 16'h0033});
    step();
    check("stl_op4", {execute, opcode}, {1'b1, 16'h0044});
    step();
    check("stl_op5", {execute, opcode}, {1'b1, 16'h0055});
    step();
    check("stl_done", done, 1'b1);
    step();

    // Full store of core ops; a write attempted mid-run must be ignored.
    for (int a = 0; a < 32; a++) write(5'(a), 16'h4000);
    for (int run = 0; run < 2; run++) begin
      pulse_start();
      cnt = 0;
      done_cyc = 0;
      done_pc = 5'h1f;
      for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
        if (run == 0 && c == 3) begin
          prog_we = 1'b1; prog_addr = 5'd0; prog_wdata = 16'hC010;
        end else begin
          prog_we = 1'b0;
        end
        step();
        if (execute) cnt++;
        if (done) begin
          done_cyc = c;
          done_pc  = pc;
          check($sformatf("full%0d_excl", run), execute, 1'b0);
        end
      end
      prog_we = 1'b0;
      check($sformatf("full%0d_issues", run), cnt, 32);
      check($sformatf("full%0d_donecyc", run), done_cyc, 33);
      check($sformatf("full%0d_pc", run), done_pc, 5'd0);
      step();
    end

    // Reset while busy: outputs drop without an edge, store goes back to HALT.
    pulse_start();
    repeat (5) step();
    check("mid_busy_pre", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_exec", execute, 1'b0);
    check("mid_busy", busy, 1'b0);
    check("mid_done", done, 1'b0);
    check("mid_pc",   pc, 5'd0);
    step();
    rst_n = 1'b1;
    step();
    pulse_start();
    check("post_busy", busy, 1'b1);
    step();
    check("post_done", done, 1'b1);
    check("post_exec", execute, 1'b0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
